// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the mips_cpu_bus memory slave.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_STALL,
    BUS_GRANT
  } bus_state_t;

  localparam logic [31:0] BUS_RESET_VECTOR = 32'hBFC00000;

  // Expands the four byte-lane enables into a 32-bit bit mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/mips_bus_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) advancing every cycle; draws random stall lengths.
module mips_bus_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] value
);

  logic feedback;

  assign feedback = value[7] ^ value[5] ^ value[4] ^ value[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) value <= SEED;
    else          value <= {value[6:0], feedback};
  end

endmodule

// File: rtl/mips_bus_memory.sv
// Word-addressed memory slave for mips_cpu_bus with wait states, byte lanes and error pulses.
// Define MEM_RANDOM_WAIT_EN to draw each access's stall length from an LFSR instead of WAIT_CYCLES.
module mips_bus_memory
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = BUS_RESET_VECTOR,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        error
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  bus_state_t  state, next_state;
  logic [3:0]  cnt, next_cnt;
  logic [3:0]  stall_len;
  logic        req, accept;
  logic [31:0] word_index;
  logic [IW-1:0] idx;
  logic        in_range, is_null, bad;

`ifdef MEM_RANDOM_WAIT_EN
  logic [7:0] lfsr_q;
  logic [4:0] draw;

  mips_bus_lfsr #(.SEED(8'hA5)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .value   (lfsr_q)
  );

  assign draw      = {1'b0, lfsr_q[3:0]} % 5'(WAIT_CYCLES + 1);
  assign stall_len = draw[3:0];
`else
  assign stall_len = 4'(WAIT_CYCLES);
`endif

  assign req         = read | write;
  assign waitrequest = req && (state != BUS_GRANT) && !(state == BUS_IDLE && stall_len == 4'd0);

  // The IDLE request cycle is the first stall cycle, so STALL counts down to 1, not 0.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    case (state)
      BUS_IDLE: begin
        if (req) begin
          if (stall_len == 4'd0) begin
            accept = 1'b1;
          end else if (stall_len == 4'd1) begin
            next_state = BUS_GRANT;
          end else begin
            next_state = BUS_STALL;
            next_cnt   = stall_len - 4'd1;
          end
        end
      end
      BUS_STALL: begin
        if (!req)                 next_state = BUS_IDLE;
        else if (cnt <= 4'd1)     next_state = BUS_GRANT;
        else                      next_cnt   = cnt - 4'd1;
      end
      BUS_GRANT: begin
        next_state = BUS_IDLE;
        accept     = req;
      end
      default: next_state = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BUS_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Unsigned subtract: addresses below the base wrap to huge indices and fall out of range.
  assign word_index = (address - ADDR_BASE) >> 2;
  assign idx       = word_index[IW-1:0];
  assign in_range  = word_index < 32'(DEPTH_WORDS);
  assign is_null   = (address == 32'd0);
  assign bad       = (read && write) || (address[1:0] != 2'b00) || (is_null ? write : !in_range);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
      error    <= 1'b0;
    end else begin
      error <= accept && bad;
      if (accept && read) readdata <= (bad || is_null) ? 32'd0 : mem[idx];
    end
  end

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (accept && write && !bad)
      mem[idx] <= (mem[idx] & ~be_to_mask(byteenable)) | (writedata & be_to_mask(byteenable));
  end

endmodule

// File: tb/tb_mips_bus_memory.sv
// Directed bench: instance a has no wait states, instance b inserts three per access.
module tb_mips_bus_memory;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        a_read = 1'b0, a_write = 1'b0, a_wait, a_err;
  logic        b_read = 1'b0, b_write = 1'b0, b_wait, b_err;
  logic [31:0] a_rdata, b_rdata;

  int tests = 0;
  int fails = 0;
  int stalls;
  logic [31:0] exp_q[$];
  logic [31:0] exp_mem [16];

  localparam logic [31:0] BASE = 32'hBFC00000;

  always #5 clk = ~clk;

  mips_bus_memory #(.ADDR_BASE(BASE), .DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .write(a_write), .read(a_read),
    .waitrequest(a_wait), .writedata(writedata), .byteenable(byteenable),
    .readdata(a_rdata), .error(a_err)
  );

  mips_bus_memory #(.ADDR_BASE(BASE), .DEPTH_WORDS(64), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .write(b_write), .read(b_read),
    .waitrequest(b_wait), .writedata(writedata), .byteenable(byteenable),
    .readdata(b_rdata), .error(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Holds a request until waitrequest drops, counting stall cycles; returns at the
  // negedge after the accept edge with the request removed.
  task automatic access(input logic sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output int n);
    int budget;
    @(negedge clk);
    address = addr; writedata = wd; byteenable = be;
    if (sel) begin b_read = rd; b_write = wr; end
    else     begin a_read = rd; a_write = wr; end
    n = 0;
    budget = 40;
    #1;
    while ((sel ? b_wait : a_wait) && budget > 0) begin
      n++;
      budget--;
      @(negedge clk);
      #1;
    end
    check("wait_bound", 32'(budget > 0), 32'd1);
    @(posedge clk);
    @(negedge clk);
    a_read = 1'b0; a_write = 1'b0; b_read = 1'b0; b_write = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_a_err",   32'(a_err), 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    check("rst_b_err",   32'(b_err), 32'd0);
    reset_n = 1'b1;

    // Zero-wait read of word 11
    access(1'b0, 1'b0, 1'b1, 32'hBFC0002C, 32'd15, 4'hF, stalls);
    check("t1_wr_stalls", 32'(stalls), 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'hBFC0002C, 32'd0, 4'hF, stalls);
    check("t1_rd_stalls", 32'(stalls), 32'd0);
    check("t1_rdata", a_rdata, 32'd15);
    check("t1_err", 32'(a_err), 32'd0);

    // Three wait states on write and readback
    access(1'b1, 1'b0, 1'b1, 32'hBFC00010, 32'hDEADBEEF, 4'hF, stalls);
    check("t2_wr_stalls", 32'(stalls), 32'd3);
    access(1'b1, 1'b1, 1'b0, 32'hBFC00010, 32'd0, 4'hF, stalls);
    check("t2_rd_stalls", 32'(stalls), 32'd3);
    check("t2_rdata", b_rdata, 32'hDEADBEEF);

    // Byte lanes
    access(1'b0, 1'b0, 1'b1, 32'hBFC00040, 32'h11223344, 4'hF, stalls);
    access(1'b0, 1'b0, 1'b1, 32'hBFC00040, 32'hAABBCCDD, 4'b0010, stalls);
    access(1'b0, 1'b1, 1'b0, 32'hBFC00040, 32'd0, 4'hF, stalls);
    check("t3_lane1", a_rdata, 32'h1122CC44);
    access(1'b0, 1'b0, 1'b1, 32'hBFC00040, 32'hFFFFFFFF, 4'b0000, stalls);
    check("t3_be0_err", 32'(a_err), 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'hBFC00040, 32'd0, 4'hF, stalls);
    check("t3_be0", a_rdata, 32'h1122CC44);

    // Rejected accesses
    access(1'b0, 1'b1, 1'b0, BASE + 32'd256, 32'd0, 4'hF, stalls);
    check("t4_oor_err", 32'(a_err), 32'd1);
    check("t4_oor_rdata", a_rdata, 32'd0);
    @(negedge clk);
    check("t4_err_pulse", 32'(a_err), 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'hBFC0002C, 32'd0, 4'hF, stalls);
    access(1'b0, 1'b1, 1'b0, 32'hBFC00002, 32'd0, 4'hF, stalls);
    check("t4_mis_err", 32'(a_err), 32'd1);
    check("t4_mis_rdata", a_rdata, 32'd0);
    access(1'b0, 1'b1, 1'b1, 32'hBFC00040, 32'h0, 4'hF, stalls);
    check("t4_rw_err", 32'(a_err), 32'd1);
    access(1'b0, 1'b0, 1'b1, BASE - 32'd4, 32'h55, 4'hF, stalls);
    check("t4_below_err", 32'(a_err), 32'd1);
    access(1'b0, 1'b1, 1'b0, 32'hBFC00040, 32'd0, 4'hF, stalls);
    check("t4_unchanged", a_rdata, 32'h1122CC44);
    check("t4_ok_err", 32'(a_err), 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 4'hF, stalls);
    check("t4_null_rd", a_rdata, 32'd0);
    check("t4_null_rd_err", 32'(a_err), 32'd0);
    access(1'b0, 1'b0, 1'b1, 32'd0, 32'h1, 4'hF, stalls);
    check("t4_null_wr_err", 32'(a_err), 32'd1);

    // Reset in the middle of a stalled write
    @(negedge clk);
    address = 32'hBFC00010; writedata = 32'h12345678; byteenable = 4'hF; b_write = 1'b1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    b_write = 1'b0;
    #1;
    check("t5_wait", 32'(b_wait), 32'd0);
    check("t5_rdata", b_rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    access(1'b1, 1'b1, 1'b0, 32'hBFC00010, 32'd0, 4'hF, stalls);
    check("t5_idle_stalls", 32'(stalls), 32'd3);
    check("t5_word", b_rdata, 32'hDEADBEEF);

    // Random traffic against a reference model on words 0..15 of instance b
    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = $urandom;
      access(1'b1, 1'b0, 1'b1, BASE + 32'(i * 4), exp_mem[i], 4'hF, stalls);
    end
    for (int i = 0; i < 24; i++) begin
      int w;
      logic [31:0] wd;
      logic [3:0] be;
      w  = $urandom_range(15, 0);
      wd = $urandom;
      be = 4'($urandom_range(15, 0));
      if ($urandom_range(1, 0) == 1) begin
        for (int l = 0; l < 4; l++)
          if (be[l]) exp_mem[w][l*8 +: 8] = wd[l*8 +: 8];
        access(1'b1, 1'b0, 1'b1, BASE + 32'(w * 4), wd, be, stalls);
      end else begin
        exp_q.push_back(exp_mem[w]);
        access(1'b1, 1'b1, 1'b0, BASE + 32'(w * 4), 32'd0, 4'hF, stalls);
        check("rnd_rdata", b_rdata, exp_q.pop_front());
      end
`ifdef MEM_RANDOM_WAIT_EN
      check("rnd_stall_max", 32'(stalls <= 3), 32'd1);
`else
      check("rnd_stalls", 32'(stalls), 32'd3);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
